// File: rtl/dart_pkg.sv
// Shared definitions for the dart game blocks: FSM states, score widths
// and player count.
package dart_pkg;

   localparam int unsigned DART_MAX_SCORE = 7;
   localparam int unsigned DART_PLAYERS   = 4;
   localparam int unsigned DART_SCORE_W   = 3;

   typedef logic [DART_SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } dart_state_t;

endpackage

// File: rtl/dart_player_acc.sv
// Per-player accumulator: running total and count of rounds in which the
// player matched the nonzero round maximum.
module dart_player_acc
   import dart_pkg::*;
#(
   parameter int unsigned TOT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             accept,
   input  score_t           score,
   input  score_t           maxs,
   output logic [TOT_W-1:0] tot,
   output logic [3:0]       win
);

   logic round_win;

   assign round_win = (score == maxs) && (maxs != '0);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         tot <= '0;
         win <= '0;
      end else if (accept) begin
         tot <= tot + TOT_W'(score);
         if (round_win) begin
            win <= win + 4'd1;
         end
      end
   end

endmodule

// File: rtl/dart_scoreboard.sv
// Multi-round four-player dart scoreboard: accumulates totals and round wins
// over ROUNDS rounds, then registers the winner and holds it until restarted.
module dart_scoreboard
   import dart_pkg::*;
#(
   parameter int unsigned ROUNDS = 5,
   parameter int unsigned TOT_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             throw_valid,
   input  logic [2:0]       A_s,
   input  logic [2:0]       B_s,
   input  logic [2:0]       C_s,
   input  logic [2:0]       D_s,
   input  logic [2:0]       Maxs,
   output logic [TOT_W-1:0] A_tot,
   output logic [TOT_W-1:0] B_tot,
   output logic [TOT_W-1:0] C_tot,
   output logic [TOT_W-1:0] D_tot,
   output logic [3:0]       A_win,
   output logic [3:0]       B_win,
   output logic [3:0]       C_win,
   output logic [3:0]       D_win,
   output logic [3:0]       round,
   output logic             busy,
   output logic             done,
   output logic [1:0]       winner,
   output logic             tie
);

   localparam int unsigned KEY_W = TOT_W + 4;

   dart_state_t state_q, state_d;
   logic        clear;
   logic        accept;

   score_t           score [DART_PLAYERS];
   logic [TOT_W-1:0] tot   [DART_PLAYERS];
   logic [3:0]       win   [DART_PLAYERS];
   logic [KEY_W-1:0] key   [DART_PLAYERS];

   assign score[0] = A_s;
   assign score[1] = B_s;
   assign score[2] = C_s;
   assign score[3] = D_s;

   for (genvar g = 0; g < DART_PLAYERS; g++) begin : g_player
      dart_player_acc #(.TOT_W(TOT_W)) u_acc (
         .clk    (clk),
         .rst    (rst),
         .clear  (clear),
         .accept (accept),
         .score  (score[g]),
         .maxs   (Maxs),
         .tot    (tot[g]),
         .win    (win[g])
      );
      assign key[g] = {tot[g], win[g]};
   end

   assign A_tot = tot[0];
   assign B_tot = tot[1];
   assign C_tot = tot[2];
   assign D_tot = tot[3];
   assign A_win = win[0];
   assign B_win = win[1];
   assign C_win = win[2];
   assign D_win = win[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               clear   = 1'b1;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (throw_valid) begin
               accept = 1'b1;
               if (round == 4'(ROUNDS - 1)) begin
                  state_d = FINAL;
               end
            end
         end
         FINAL:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         round <= '0;
      end else if (accept) begin
         round <= round + 4'd1;
      end
   end

   // Strict '>' at every node keeps the lower index on equal keys.
   logic [1:0]       ab_idx, cd_idx, sel_idx;
   logic [KEY_W-1:0] ab_key, cd_key, sel_key;
   logic             sel_tie;

   always_comb begin
      ab_idx = (key[1] > key[0]) ? 2'd1 : 2'd0;
      ab_key = (key[1] > key[0]) ? key[1] : key[0];
      cd_idx = (key[3] > key[2]) ? 2'd3 : 2'd2;
      cd_key = (key[3] > key[2]) ? key[3] : key[2];
      sel_idx = (cd_key > ab_key) ? cd_idx : ab_idx;
      sel_key = (cd_key > ab_key) ? cd_key : ab_key;
      sel_tie = 1'b0;
      for (int unsigned i = 0; i < DART_PLAYERS; i++) begin
         if ((2'(i) != sel_idx) && (key[i] == sel_key)) begin
            sel_tie = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         winner <= '0;
         tie    <= 1'b0;
      end else if (state_q == FINAL) begin
         winner <= sel_idx;
         tie    <= sel_tie;
      end
   end

   assign busy = (state_q == PLAY) || (state_q == FINAL);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_dart_scoreboard.sv
// Scoreboard bench for dart_scoreboard with ROUNDS=3: expected snapshots and
// game results are queued by the stimulus and compared by monitor processes.
module tb_dart_scoreboard;

   logic       clk = 1'b0;
   logic       rst, start, throw_valid;
   logic [2:0] A_s, B_s, C_s, D_s, Maxs;
   logic [5:0] A_tot, B_tot, C_tot, D_tot;
   logic [3:0] A_win, B_win, C_win, D_win, round;
   logic       busy, done, tie;
   logic [1:0] winner;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string tag;
      int    at, bt, ct, dt;
      int    aw, bw, cw, dw;
      int    rnd, busy, done, winner, tie;
   } exp_t;

   exp_t snap_q [$];
   exp_t done_q [$];
   event snap_ev;
   logic done_prev = 1'b0;

   dart_scoreboard #(.ROUNDS(3), .TOT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .throw_valid(throw_valid),
      .A_s(A_s), .B_s(B_s), .C_s(C_s), .D_s(D_s), .Maxs(Maxs),
      .A_tot(A_tot), .B_tot(B_tot), .C_tot(C_tot), .D_tot(D_tot),
      .A_win(A_win), .B_win(B_win), .C_win(C_win), .D_win(D_win),
      .round(round), .busy(busy), .done(done), .winner(winner), .tie(tie)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(string tag, int at, int bt, int ct, int dt,
                               int aw, int bw, int cw, int dw, int rnd,
                               int bsy, int dn, int wnr, int te);
      exp_t e;
      e.tag = tag; e.at = at; e.bt = bt; e.ct = ct; e.dt = dt;
      e.aw = aw; e.bw = bw; e.cw = cw; e.dw = dw; e.rnd = rnd;
      e.busy = bsy; e.done = dn; e.winner = wnr; e.tie = te;
      return e;
   endfunction

   function automatic void chk(string tag, string field, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %0d expected %0d", tag, field, act, exp);
      end
   endfunction

   function automatic void check(exp_t e);
      chk(e.tag, "A_tot", int'(A_tot), e.at);
      chk(e.tag, "B_tot", int'(B_tot), e.bt);
      chk(e.tag, "C_tot", int'(C_tot), e.ct);
      chk(e.tag, "D_tot", int'(D_tot), e.dt);
      chk(e.tag, "A_win", int'(A_win), e.aw);
      chk(e.tag, "B_win", int'(B_win), e.bw);
      chk(e.tag, "C_win", int'(C_win), e.cw);
      chk(e.tag, "D_win", int'(D_win), e.dw);
      chk(e.tag, "round", int'(round), e.rnd);
      chk(e.tag, "busy", int'(busy), e.busy);
      chk(e.tag, "done", int'(done), e.done);
      chk(e.tag, "winner", int'(winner), e.winner);
      chk(e.tag, "tie", int'(tie), e.tie);
   endfunction

   // Snapshot monitor: compares whenever the stimulus requests a sample.
   initial begin
      exp_t e;
      forever begin
         @(snap_ev);
         if (snap_q.size() != 0) begin
            e = snap_q.pop_front();
            check(e);
         end
      end
   end

   // Result monitor: compares each game result when done rises.
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_prev) begin
         if (done_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending game");
         end else begin
            e = done_q.pop_front();
            check(e);
         end
      end
      done_prev = done;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(exp_t e);
      snap_q.push_back(e);
      -> snap_ev;
      #0;
   endtask

   task automatic set_s(int a, int b, int c, int d, int m);
      A_s = 3'(a); B_s = 3'(b); C_s = 3'(c); D_s = 3'(d); Maxs = 3'(m);
   endtask

   task automatic throw_r(int a, int b, int c, int d, int m);
      set_s(a, b, c, d, m);
      throw_valid = 1'b1;
      step();
      throw_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(string tag);
      int k = 0;
      while (!done && k < 8) begin
         step();
         k++;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s.timeout: got done=0 expected done=1 within 8 cycles", tag);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; throw_valid = 1'b0;
      set_s(0, 0, 0, 0, 0);
      step(); step();
      rst = 1'b0;
      snap(mk("reset", 0,0,0,0, 0,0,0,0, 0, 0,0,0,0));

      // Throws in IDLE are ignored; start with a throw only starts.
      throw_r(7, 7, 7, 7, 7);
      snap(mk("idle_throw", 0,0,0,0, 0,0,0,0, 0, 0,0,0,0));
      start = 1'b1; throw_valid = 1'b1;
      step();
      start = 1'b0; throw_valid = 1'b0;
      snap(mk("start_idle", 0,0,0,0, 0,0,0,0, 0, 1,0,0,0));

      // Reset mid-game after two rounds.
      throw_r(7, 1, 2, 0, 7);
      throw_r(3, 5, 5, 1, 5);
      snap(mk("mid_game", 10,6,7,1, 1,1,1,0, 2, 1,0,0,0));
      rst = 1'b1;
      step();
      rst = 1'b0;
      snap(mk("rst_mid", 0,0,0,0, 0,0,0,0, 0, 0,0,0,0));

      // Game 1: clear winner A, exact FINAL/DONE timing, start in PLAY ignored.
      pulse_start();
      throw_r(7, 1, 2, 0, 7);
      pulse_start();
      snap(mk("start_in_play", 7,1,2,0, 1,0,0,0, 1, 1,0,0,0));
      throw_r(3, 5, 5, 1, 5);
      done_q.push_back(mk("game1", 16,8,9,3, 2,1,1,0, 3, 0,1,0,0));
      throw_r(6, 2, 2, 2, 6);
      snap(mk("final_cycle", 16,8,9,3, 2,1,1,0, 3, 1,0,0,0));
      step();
      snap(mk("done_cycle", 16,8,9,3, 2,1,1,0, 3, 0,1,0,0));

      // Throws in DONE are held off; start+throw in DONE restarts cleanly.
      throw_r(7, 7, 7, 7, 7);
      snap(mk("done_throw", 16,8,9,3, 2,1,1,0, 3, 0,1,0,0));
      set_s(7, 7, 7, 7, 7);
      start = 1'b1; throw_valid = 1'b1;
      step();
      start = 1'b0; throw_valid = 1'b0;
      snap(mk("start_done", 0,0,0,0, 0,0,0,0, 0, 1,0,0,0));

      // Game 2: equal totals, A has more wins.
      done_q.push_back(mk("game2", 14,14,0,0, 2,1,0,0, 3, 0,1,0,0));
      throw_r(7, 6, 0, 0, 7);
      throw_r(0, 7, 0, 0, 7);
      throw_r(7, 1, 0, 0, 7);
      wait_done("game2");

      // Game 3: equal totals, B has more wins.
      pulse_start();
      done_q.push_back(mk("game3", 14,14,0,0, 1,2,0,0, 3, 0,1,1,0));
      throw_r(6, 7, 0, 0, 7);
      throw_r(7, 0, 0, 0, 7);
      throw_r(1, 7, 0, 0, 7);
      wait_done("game3");

      // Game 4: full four-way tie.
      pulse_start();
      done_q.push_back(mk("game4", 12,12,12,12, 3,3,3,3, 3, 0,1,0,1));
      for (int i = 0; i < 3; i++) throw_r(4, 4, 4, 4, 4);
      wait_done("game4");

      // Game 5: zero rounds count but award no wins; D wins.
      pulse_start();
      throw_r(0, 0, 0, 0, 0);
      snap(mk("zero_round", 0,0,0,0, 0,0,0,0, 1, 1,0,0,0));
      done_q.push_back(mk("game5", 1,2,3,7, 0,0,0,1, 3, 0,1,3,0));
      throw_r(1, 2, 3, 7, 7);
      throw_r(0, 0, 0, 0, 0);
      wait_done("game5");

      // Game 6: B and C fully tied ahead of A; index picks B.
      pulse_start();
      done_q.push_back(mk("game6", 4,7,7,0, 1,2,2,0, 3, 0,1,1,1));
      throw_r(2, 5, 5, 0, 5);
      throw_r(2, 2, 2, 0, 2);
      throw_r(0, 0, 0, 0, 0);
      wait_done("game6");

      step(); step();
      while (done_q.size() != 0) begin
         exp_t e;
         e = done_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL %s.missing: got no done edge expected one", e.tag);
      end
      while (snap_q.size() != 0) begin
         exp_t e;
         e = snap_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL %s.unsampled: got no sample expected one", e.tag);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dart_scoreboard.md
# dart_scoreboard

Multi-round scoreboard for the four-player dart game. It sits directly downstream of the per-throw scorer, which maps each player's (x,y) hit to a 0–7 zone score and gives the round maximum. It consumes one round of four scores per accepted `throw_valid` and accumulates per-player totals and round wins over `ROUNDS` rounds. It then declares a winner and holds the result until the next game is started.

## Interface
Parameters:
- `ROUNDS`, default 5: rounds per game; legal range 1–15.
- `TOT_W`, default 6: total-score width; 7*ROUNDS must be ≤ 2^TOT_W−1.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin new game; sampled in IDLE and DONE only.
- `throw_valid`  in  1  one round of scores present; accepted only in PLAY.
- `A_s`, `B_s`, `C_s`, `D_s`  in  3 each  per-player zone score for this round, 0–7.
- `Maxs`  in  3  round maximum from the scorer.
- `A_tot`, `B_tot`, `C_tot`, `D_tot`  out  TOT_W each  running totals.
- `A_win`, `B_win`, `C_win`, `D_win`  out  4 each  count of rounds the player matched the nonzero round maximum.
- `round`  out  4  rounds accepted so far in the current game.
- `busy`  out  1  high in PLAY and FINAL.
- `done`  out  1  high in DONE.
- `winner`  out  2  winning player index (0=A … 3=D); valid when `done`.
- `tie`  out  1  winner chosen by index tiebreak; valid when `done`.

## Operation
- FSM states: IDLE, PLAY, FINAL, DONE.
- IDLE: `start` clears all totals, win counts and `round`, then goes to PLAY.
- PLAY: each cycle with `throw_valid`=1 is one accepted round.
  - Each total adds its score, zero-extended to TOT_W.
  - Each win counter increments if its score equals `Maxs` and `Maxs`≠0.
  - `round` increments.
  - When the accepted round makes `round`==ROUNDS, the next state is FINAL. Otherwise stay in PLAY.
  - `start` is ignored in PLAY.
- FINAL: one cycle. Computes `winner` and `tie`, then goes to DONE.
  - The highest total wins.
  - Equal totals are broken by more round wins.
  - If still equal, the lowest index wins and `tie`=1.
  - `tie`=1 only when the final decision needed the index rule.
- DONE: totals, wins, `winner` and `tie` are held.
  - `throw_valid` is ignored.
  - `start` clears everything and goes to PLAY, exactly as from IDLE.
- `throw_valid` is ignored in IDLE, FINAL and DONE.
- The block does not cross-check `Maxs` against the scores. Score values are trusted.
- Arithmetic is unsigned. Totals cannot overflow given the parameter constraint. Win counters cannot exceed ROUNDS.

## Timing
- Reset values: state=IDLE, all totals=0, all wins=0, `round`=0, `busy`=0, `done`=0, `winner`=0, `tie`=0.
- `rst` overrides everything in any state, including mid-game and in FINAL. Partial results are discarded.
- `start` at edge t: state=PLAY and `busy`=1 at t+1. Counters read 0 at t+1.
- Accept at edge t: updated totals, wins and `round` are visible at t+1.
- Back-to-back `throw_valid` is legal. Throughput is one round per cycle.
- Last round accepted at t: FINAL at t+1, `done`=1 with valid `winner`/`tie` at t+2. `busy` drops at t+2.
- `start` and `throw_valid` both high in IDLE: only `start` is acted on.
- `start` and `throw_valid` both high in DONE: only `start` is acted on. The throw is not counted.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `dart_pkg` holds:
  - state encodings IDLE/PLAY/FINAL/DONE;
  - `DART_MAX_SCORE`=7;
  - `DART_PLAYERS`=4;
  - score width 3.
- One sub-module, `dart_player_acc`, instantiated 4×. Per player it holds the total and win registers, with clear, accept, score and `Maxs` inputs.
- Winner selection (pairwise compare tree on {total, wins}, lowest-index priority) stays in the top level and is registered in FINAL.

## Test plan
- Reset: assert `rst` mid-PLAY after 2 rounds → next cycle all outputs are at reset values and state is IDLE.
- ROUNDS=3 clear winner:
  - round 1: A=7, B=1, C=2, D=0, Maxs=7;
  - round 2: 3,5,5,1, Maxs=5;
  - round 3: 6,2,2,2, Maxs=6;
  - required: A_tot=16, B_tot=8, C_tot=9, D_tot=3; `winner`=0, `tie`=0, `done` 2 cycles after the third accept.
- Win tiebreak:
  - scores (7,6), (0,1), (7,6), Maxs=7,1,7;
  - required: A_tot=14, B_tot=13. Use instead A:(7,0,7), B:(6,7,1) with Maxs 7,7,7 → totals A=14, B=14; wins A=2, B=1; `winner`=0, `tie`=0.
- Full tie: all players score 4 every round with Maxs=4 → totals 12 each, wins 3 each, `winner`=0, `tie`=1.
- Zero round: all scores 0 and Maxs=0 → no win increments; `round` still increments.
- Gating:
  - `throw_valid` in IDLE/DONE leaves counters unchanged.
  - `start` in PLAY is ignored.
  - `start` in DONE clears everything and `busy`=1 on the next cycle.
